data_cache: RTL

//  Direct-mapped, write-through, no-write-allocate data cache placed between the

---
 rtl/cache_pkg.sv | 29 ++
 rtl/data_cache_if.sv | 24 ++
 rtl/cache_data_array.sv | 27 ++
 rtl/data_cache.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the direct-mapped write-through data cache.
package cache_pkg;

  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefNumLines  = 16;
  localparam int unsigned DefLineWords = 4;

  localparam int unsigned OffW = $clog2(DefLineWords);
  localparam int unsigned IdxW = $clog2(DefNumLines);
  localparam int unsigned TagW = DefAddrWidth - IdxW - OffW - 2;

  typedef enum logic [1:0] {
    StIdle,
    StRefill,
    StWrite
  } state_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) merged[8*k +: 8] = new_word[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// Backing-memory beat bus: request held stable until the ready edge.
interface data_cache_if #(
  parameter int unsigned AW = 32
) ();

  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [3:0]    mem_byte_en_o;
  logic [31:0]   mem_rdata_i;
  logic          mem_ready_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_byte_en_o,
    input  mem_rdata_i, mem_ready_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_byte_en_o,
    output mem_rdata_i, mem_ready_i
  );

endinterface

// File: rtl/cache_data_array.sv
// Cache word storage: asynchronous read, synchronous byte-enabled write.
module cache_data_array
  import cache_pkg::*;
#(
  parameter int unsigned NUM_LINES  = DefNumLines,
  parameter int unsigned LINE_WORDS = DefLineWords
) (
  input  logic                          clk,
  input  logic [$clog2(NUM_LINES)-1:0]  rd_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_off,
  output logic [31:0]                   rd_data,
  input  logic                          we,
  input  logic [$clog2(NUM_LINES)-1:0]  wr_idx,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_off,
  input  logic [31:0]                   wr_data,
  input  logic [3:0]                    wr_be
);

  logic [31:0] words_q [NUM_LINES*LINE_WORDS];

  always_ff @(posedge clk) begin
    if (we) words_q[{wr_idx, wr_off}] <= byte_merge(words_q[{wr_idx, wr_off}], wr_data, wr_be);
  end

  assign rd_data = words_q[{rd_idx, rd_off}];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache for the M stage.
module data_cache
  import cache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned NUM_LINES  = DefNumLines,
  parameter int unsigned LINE_WORDS = DefLineWords
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  rd_en_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [3:0]            byte_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  stall_o,
  data_cache_if.master          mem
);

  localparam int unsigned OFF = $clog2(LINE_WORDS);
  localparam int unsigned IDX = $clog2(NUM_LINES);
  localparam int unsigned TAG = ADDR_WIDTH - IDX - OFF - 2;
  localparam int unsigned WAW = ADDR_WIDTH - 2;

  state_e          state_q, state_d;
  logic [OFF-1:0]  cnt_q, cnt_d;
  logic            wr_done_q, wr_done_d;
  logic [NUM_LINES-1:0] valid_q;
  logic [TAG-1:0]  tag_q [NUM_LINES];
  logic [WAW-1:0]  addr_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;

  logic            latch, fill_done;
  logic            arr_we;
  logic [OFF-1:0]  arr_off;
  logic [31:0]     arr_wdata, arr_rdata;
  logic [3:0]      arr_be;

  logic [OFF-1:0]  c_off, q_off;
  logic [IDX-1:0]  c_idx, q_idx;
  logic [TAG-1:0]  c_tag, q_tag;
  logic            cpu_hit, q_hit;
  logic            unused_addr_lsb;

  assign c_off = addr_i[OFF+1:2];
  assign c_idx = addr_i[IDX+OFF+1:OFF+2];
  assign c_tag = addr_i[ADDR_WIDTH-1:IDX+OFF+2];
  assign q_off = addr_q[OFF-1:0];
  assign q_idx = addr_q[IDX+OFF-1:OFF];
  assign q_tag = addr_q[WAW-1:IDX+OFF];
  assign unused_addr_lsb = ^addr_i[1:0];

  assign cpu_hit = valid_q[c_idx] && (tag_q[c_idx] == c_tag);
  assign q_hit   = valid_q[q_idx] && (tag_q[q_idx] == q_tag);

  cache_data_array #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_data_array (
    .clk     (clk),
    .rd_idx  (c_idx),
    .rd_off  (c_off),
    .rd_data (arr_rdata),
    .we      (arr_we),
    .wr_idx  (q_idx),
    .wr_off  (arr_off),
    .wr_data (arr_wdata),
    .wr_be   (arr_be)
  );

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    wr_done_d         = 1'b0;
    latch             = 1'b0;
    fill_done         = 1'b0;
    stall_o           = 1'b0;
    rd_data_o         = '0;
    mem.mem_req_o     = 1'b0;
    mem.mem_we_o      = 1'b0;
    mem.mem_addr_o    = '0;
    mem.mem_wdata_o   = '0;
    mem.mem_byte_en_o = '0;
    arr_we            = 1'b0;
    arr_off           = q_off;
    arr_wdata         = wdata_q;
    arr_be            = be_q;

    unique case (state_q)
      StIdle: begin
        // wr_done_q masks the still-held store for the one cycle after it retires.
        if (wr_en_i && !wr_done_q) begin
          stall_o = 1'b1;
          latch   = 1'b1;
          state_d = StWrite;
        end else if (rd_en_i && !wr_en_i) begin
          if (cpu_hit) begin
            rd_data_o = arr_rdata;
          end else begin
            stall_o = 1'b1;
            latch   = 1'b1;
            cnt_d   = '0;
            state_d = StRefill;
          end
        end
      end
      StRefill: begin
        stall_o        = 1'b1;
        mem.mem_req_o  = 1'b1;
        mem.mem_addr_o = {q_tag, q_idx, cnt_q, 2'b00};
        arr_off        = cnt_q;
        arr_wdata      = mem.mem_rdata_i;
        arr_be         = 4'hF;
        arr_we         = mem.mem_ready_i;
        if (mem.mem_ready_i) begin
          if (cnt_q == OFF'(LINE_WORDS - 1)) begin
            fill_done = 1'b1;
            state_d   = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StWrite: begin
        stall_o           = 1'b1;
        mem.mem_req_o     = 1'b1;
        mem.mem_we_o      = 1'b1;
        mem.mem_addr_o    = {addr_q, 2'b00};
        mem.mem_wdata_o   = wdata_q;
        mem.mem_byte_en_o = be_q;
        if (mem.mem_ready_i) begin
          arr_we    = q_hit;
          wr_done_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      wr_done_q <= 1'b0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_done_q <= wr_done_d;
      if (fill_done) valid_q[q_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (latch) begin
      addr_q  <= addr_i[ADDR_WIDTH-1:2];
      wdata_q <= wr_data_i;
      be_q    <= byte_en_i;
    end
    if (fill_done) tag_q[q_idx] <= q_tag;
  end

endmodule
